// File: rtl/truth_table_lut.sv
// -----------------------------------------------------------------------------
// truth_table_lut
//
// N-input truth-table gate with a runtime-reprogrammable table, an input
// settle filter and a registered output. The input vector must hold steady
// for SETTLE cycles before the table is consulted. A new table is shifted in
// serially into a shadow register while the old table keeps evaluating; the
// shadow is committed in one step when the last bit arrives.
//
// Parameters
//   N_IN    number of inputs (1..6); table depth is 2^N_IN rows
//   INIT    reset table; bit i is the output for input row i
//   SETTLE  cycles the input must stay stable before evaluation (1..255)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in          input vector; in[N_IN-1] is the row-index MSB
//   cfg_start   pulse that begins or restarts a table load
//   cfg_valid   cfg_bit is valid this cycle
//   cfg_bit     serial table bit, highest row first
//   cfg_ready   high while loading; a bit is taken on cfg_valid && cfg_ready
//   cfg_busy    high while loading
//   out         registered table[in_q]
//   out_valid   out reflects the current stable input and active table
//   out_change  one-cycle pulse on the cycle out changes value
// -----------------------------------------------------------------------------
module truth_table_lut #(
   parameter int                   N_IN   = 3,
   parameter logic [(1<<N_IN)-1:0] INIT   = '0,
   parameter int                   SETTLE = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_IN-1:0] in,
   input  logic            cfg_start,
   input  logic            cfg_valid,
   input  logic            cfg_bit,
   output logic            cfg_ready,
   output logic            cfg_busy,
   output logic            out,
   output logic            out_valid,
   output logic            out_change
);

   localparam int ROWS = 1 << N_IN;
   localparam int BCW  = $clog2(ROWS + 1);

   localparam logic [BCW-1:0] LAST_BIT  = BCW'(ROWS - 1);
   localparam logic [7:0]     SETTLE_C  = 8'(SETTLE);
   localparam logic [7:0]     SETTLE_M1 = 8'(SETTLE - 1);

   localparam logic [0:0] ST_RUN  = 1'b0;
   localparam logic [0:0] ST_LOAD = 1'b1;

   logic [0:0]      state;
   logic [ROWS-1:0] active_tbl;
   logic [ROWS-1:0] shadow_tbl;
   logic [ROWS-1:0] shadow_nxt;
   logic [BCW-1:0]  bit_cnt;
   logic [N_IN-1:0] in_q;
   logic [7:0]      stab_cnt;
   logic            in_load;
   logic            bit_acc;
   logic            commit;
   logic            tbl_bit;

   assign in_load = (state == ST_LOAD);

   // cfg_start has priority over a bit presented in the same cycle
   assign bit_acc = in_load && cfg_valid && !cfg_start;
   assign commit  = bit_acc && (bit_cnt == LAST_BIT);

   // MSB-first: after ROWS shifts the first bit sits at row ROWS-1
   assign shadow_nxt = {shadow_tbl[ROWS-2:0], cfg_bit};

   assign tbl_bit = active_tbl[in_q];

   assign cfg_ready = in_load;
   assign cfg_busy  = in_load;

   // Configuration state machine and table registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_RUN;
         bit_cnt    <= '0;
         shadow_tbl <= '0;
         active_tbl <= INIT;
      end else if (state == ST_RUN) begin
         if (cfg_start) begin
            state      <= ST_LOAD;
            bit_cnt    <= '0;
            shadow_tbl <= '0;
         end
      end else begin
         if (cfg_start) begin
            bit_cnt    <= '0;
            shadow_tbl <= '0;
         end else if (bit_acc) begin
            shadow_tbl <= shadow_nxt;
            if (commit) begin
               active_tbl <= shadow_nxt;
               bit_cnt    <= '0;
               state      <= ST_RUN;
            end else begin
               bit_cnt <= bit_cnt + BCW'(1);
            end
         end
      end
   end

   // Settle filter and output register. An input change and a commit on the
   // same edge both restart the settle count; out holds across the restart.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q       <= '0;
         stab_cnt   <= '0;
         out        <= 1'b0;
         out_valid  <= 1'b0;
         out_change <= 1'b0;
      end else if (in != in_q) begin
         in_q       <= in;
         stab_cnt   <= '0;
         out_valid  <= 1'b0;
         out_change <= 1'b0;
      end else if (commit) begin
         stab_cnt   <= '0;
         out_valid  <= 1'b0;
         out_change <= 1'b0;
      end else if (stab_cnt < SETTLE_C) begin
         stab_cnt <= stab_cnt + 8'd1;
         if (stab_cnt == SETTLE_M1) begin
            out        <= tbl_bit;
            out_valid  <= 1'b1;
            out_change <= (out != tbl_bit);
         end else begin
            out_change <= 1'b0;
         end
      end else begin
         out        <= tbl_bit;
         out_change <= (out != tbl_bit);
      end
   end

endmodule

// File: tb/tb_truth_table_lut.sv
// -----------------------------------------------------------------------------
// tb_truth_table_lut
//
// Directed self-checking bench. Instance a: N_IN=3, INIT=8'h90, SETTLE=4.
// Instance b: N_IN=4, INIT=16'hA5C3, SETTLE=1. Inputs are driven 1 time unit
// after a rising edge and outputs are sampled at that same point, so each
// sample shows the registers as updated by the edge just passed.
// -----------------------------------------------------------------------------
module tb_truth_table_lut;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] in_a;
   logic       cfg_start_a, cfg_valid_a, cfg_bit_a;
   logic       cfg_ready_a, cfg_busy_a, out_a, out_valid_a, out_change_a;
   logic [3:0] in_b;
   logic       cfg_ready_b, cfg_busy_b, out_b, out_valid_b, out_change_b;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   truth_table_lut #(.N_IN(3), .INIT(8'h90), .SETTLE(4)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in_a),
      .cfg_start  (cfg_start_a),
      .cfg_valid  (cfg_valid_a),
      .cfg_bit    (cfg_bit_a),
      .cfg_ready  (cfg_ready_a),
      .cfg_busy   (cfg_busy_a),
      .out        (out_a),
      .out_valid  (out_valid_a),
      .out_change (out_change_a)
   );

   truth_table_lut #(.N_IN(4), .INIT(16'hA5C3), .SETTLE(1)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .in         (in_b),
      .cfg_start  (1'b0),
      .cfg_valid  (1'b0),
      .cfg_bit    (1'b0),
      .cfg_ready  (cfg_ready_b),
      .cfg_busy   (cfg_busy_b),
      .out        (out_b),
      .out_valid  (out_valid_b),
      .out_change (out_change_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      in_a        = 3'b000;
      in_b        = 4'b0000;
      cfg_start_a = 1'b0;
      cfg_valid_a = 1'b0;
      cfg_bit_a   = 1'b0;
      #3;
      n_checks++;
      if ({out_a, out_valid_a, out_change_a, cfg_ready_a, cfg_busy_a} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_a: outputs=%b required 00000",
                  {out_a, out_valid_a, out_change_a, cfg_ready_a, cfg_busy_a});
      end
      n_checks++;
      if ({out_b, out_valid_b, out_change_b, cfg_ready_b, cfg_busy_b} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_b: outputs=%b required 00000",
                  {out_b, out_valid_b, out_change_b, cfg_ready_b, cfg_busy_b});
      end
      tick();
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         n_checks++;
         if ({out_a, out_valid_a, out_change_a} !== {1'b0, (k >= 4), 1'b0}) begin
            n_fail++;
            $display("FAIL reset_settle k=%0d: out/valid/change=%b%b%b required 0%b0",
                     k, out_a, out_valid_a, out_change_a, (k >= 4));
         end
      end
   endtask

   task automatic test_settle();
      int pulses = 0;
      in_a = 3'b100;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (out_change_a === 1'b1) pulses++;
         n_checks++;
         if ({out_a, out_valid_a, out_change_a} !== {(k >= 5), (k >= 5), (k == 5)}) begin
            n_fail++;
            $display("FAIL settle k=%0d: out/valid/change=%b%b%b required %b%b%b",
                     k, out_a, out_valid_a, out_change_a, (k >= 5), (k >= 5), (k == 5));
         end
      end
      n_checks++;
      if (pulses != 1) begin
         n_fail++;
         $display("FAIL settle_pulses: got %0d required 1", pulses);
      end
   endtask

   task automatic test_glitch();
      int low_cycles = 0;
      in_a = 3'b000;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 2) in_a = 3'b100;
         if (out_valid_a === 1'b0) low_cycles++;
         n_checks++;
         if ({out_a, out_valid_a, out_change_a} !== {1'b1, (k >= 7), 1'b0}) begin
            n_fail++;
            $display("FAIL glitch k=%0d: out/valid/change=%b%b%b required 1%b0",
                     k, out_a, out_valid_a, out_change_a, (k >= 7));
         end
      end
      n_checks++;
      if (low_cycles != 6) begin
         n_fail++;
         $display("FAIL glitch_valid_low: got %0d cycles required 6", low_cycles);
      end
   endtask

   task automatic test_reprogram();
      logic [7:0] bits = 8'h09;
      in_a = 3'b000;
      repeat (6) tick();
      n_checks++;
      if ({out_a, out_valid_a} !== 2'b01) begin
         n_fail++;
         $display("FAIL reprog_pre: out/valid=%b%b required 01", out_a, out_valid_a);
      end
      cfg_start_a = 1'b1;
      tick();
      cfg_start_a = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         n_checks++;
         if ({cfg_busy_a, cfg_ready_a, out_a, out_valid_a} !== 4'b1101) begin
            n_fail++;
            $display("FAIL reprog_load bit=%0d: busy/ready/out/valid=%b%b%b%b required 1101",
                     i, cfg_busy_a, cfg_ready_a, out_a, out_valid_a);
         end
         repeat ($urandom_range(0, 2)) tick();
         cfg_valid_a = 1'b1;
         cfg_bit_a   = bits[i];
         tick();
         cfg_valid_a = 1'b0;
         cfg_bit_a   = 1'b0;
      end
      n_checks++;
      if ({cfg_busy_a, cfg_ready_a, out_a, out_valid_a} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reprog_commit: busy/ready/out/valid=%b%b%b%b required 0000",
                  cfg_busy_a, cfg_ready_a, out_a, out_valid_a);
      end
      for (int k = 1; k <= 5; k++) begin
         tick();
         n_checks++;
         if ({out_a, out_valid_a, out_change_a} !== {(k >= 4), (k >= 4), (k == 4)}) begin
            n_fail++;
            $display("FAIL reprog_eval k=%0d: out/valid/change=%b%b%b required %b%b%b",
                     k, out_a, out_valid_a, out_change_a, (k >= 4), (k >= 4), (k == 4));
         end
      end
   endtask

   task automatic test_restart_collision();
      cfg_start_a = 1'b1;
      tick();
      cfg_start_a = 1'b0;
      // five partial bits, later discarded
      for (int i = 0; i < 5; i++) begin
         cfg_valid_a = 1'b1;
         cfg_bit_a   = 1'b0;
         tick();
      end
      cfg_valid_a = 1'b0;
      cfg_start_a = 1'b1;
      tick();
      cfg_start_a = 1'b0;
      // three more partial zeros, then a restart that collides with a bit
      for (int i = 0; i < 3; i++) begin
         cfg_valid_a = 1'b1;
         cfg_bit_a   = 1'b0;
         tick();
      end
      cfg_start_a = 1'b1;
      cfg_valid_a = 1'b1;
      cfg_bit_a   = 1'b0;
      tick();
      cfg_start_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (cfg_busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_busy bit=%0d: busy=%b required 1", i, cfg_busy_a);
         end
         cfg_valid_a = 1'b1;
         cfg_bit_a   = 1'b1;
         tick();
      end
      cfg_valid_a = 1'b0;
      cfg_bit_a   = 1'b0;
      n_checks++;
      if (cfg_busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_commit: busy=%b required 0", cfg_busy_a);
      end
      for (int r = 0; r < 8; r++) begin
         in_a = 3'(r);
         repeat (6) tick();
         n_checks++;
         if ({out_a, out_valid_a} !== 2'b11) begin
            n_fail++;
            $display("FAIL restart_row%0d: out/valid=%b%b required 11", r, out_a, out_valid_a);
         end
      end
   endtask

   task automatic test_reset_mid_load();
      logic [7:0] init_a = 8'h90;
      cfg_start_a = 1'b1;
      tick();
      cfg_start_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cfg_valid_a = 1'b1;
         cfg_bit_a   = 1'b0;
         tick();
      end
      cfg_valid_a = 1'b0;
      rst_n = 1'b0;
      in_a  = 3'b000;
      #2;
      n_checks++;
      if ({out_a, out_valid_a, out_change_a, cfg_ready_a, cfg_busy_a} !== 5'b0) begin
         n_fail++;
         $display("FAIL midload_reset: outputs=%b required 00000",
                  {out_a, out_valid_a, out_change_a, cfg_ready_a, cfg_busy_a});
      end
      tick();
      n_checks++;
      if (cfg_busy_a !== 1'b0) begin
         n_fail++;
         $display("FAIL midload_busy: busy=%b required 0", cfg_busy_a);
      end
      rst_n = 1'b1;
      repeat (6) tick();
      for (int r = 0; r < 8; r++) begin
         in_a = 3'(r);
         repeat (6) tick();
         n_checks++;
         if ({out_a, out_valid_a} !== {init_a[r], 1'b1}) begin
            n_fail++;
            $display("FAIL midload_row%0d: out/valid=%b%b required %b1",
                     r, out_a, out_valid_a, init_a[r]);
         end
      end
   endtask

   task automatic test_sweep();
      logic [15:0] init_b = 16'hA5C3;
      logic        prev;
      int          pulses = 0;
      in_b = 4'd0;
      repeat (3) tick();
      n_checks++;
      if ({out_b, out_valid_b} !== 2'b11) begin
         n_fail++;
         $display("FAIL sweep_row0: out/valid=%b%b required 11", out_b, out_valid_b);
      end
      prev = 1'b1;
      for (int r = 1; r < 16; r++) begin
         in_b = 4'(r);
         tick();
         n_checks++;
         if ({out_b, out_valid_b, out_change_b} !== {prev, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL sweep_cap row%0d: out/valid/change=%b%b%b required %b00",
                     r, out_b, out_valid_b, out_change_b, prev);
         end
         tick();
         if (out_change_b === 1'b1) pulses++;
         n_checks++;
         if ({out_b, out_valid_b, out_change_b} !== {init_b[r], 1'b1, (init_b[r] != prev)}) begin
            n_fail++;
            $display("FAIL sweep_eval row%0d: out/valid/change=%b%b%b required %b1%b",
                     r, out_b, out_valid_b, out_change_b, init_b[r], (init_b[r] != prev));
         end
         tick();
         n_checks++;
         if (out_change_b !== 1'b0) begin
            n_fail++;
            $display("FAIL sweep_hold row%0d: change=%b required 0", r, out_change_b);
         end
         prev = init_b[r];
      end
      n_checks++;
      if (pulses != 8) begin
         n_fail++;
         $display("FAIL sweep_pulses: got %0d required 8", pulses);
      end
   endtask

   initial begin
      test_reset();
      test_settle();
      test_glitch();
      test_reprogram();
      test_restart_collision();
      test_reset_mid_load();
      test_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/truth_table_lut.md
# truth_table_lut

Parametrised, runtime-reprogrammable N-input truth-table gate with input settle filtering and a registered output. The output updates only after the input vector has been stable for a set number of cycles. The whole table can be replaced through a serial config port while the block keeps evaluating on the old table. It generalises the fixed 3-input case-statement gates in the circuit library: one block covers every N-input function, and the function can change in-system.

## Interface
- N_IN, 3, number of inputs; table depth is 2^N_IN rows; legal range 1..6
- INIT, 0, 2^N_IN-bit reset table; bit i is the output for input row i
- SETTLE, 4, cycles the input must stay stable before evaluation; legal range 1..255

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in  input  N_IN  input vector; in[N_IN-1] is the row-index MSB (in1)
- cfg_start  input  1  one-cycle pulse that begins or restarts a table load
- cfg_valid  input  1  cfg_bit is valid this cycle
- cfg_bit  input  1  serial table bit
- cfg_ready  output  1  high while in LOAD; a bit is accepted when cfg_valid && cfg_ready
- cfg_busy  output  1  high while in LOAD
- out  output  1  registered result of table[in_q]
- out_valid  output  1  out reflects the current stable input and the active table
- out_change  output  1  one-cycle pulse on the cycle out changes value

## Operation
- Reset (async assert): active table = INIT, shadow = 0, in_q = 0, stab_cnt = 0, bit_cnt = 0, state = RUN. out, out_valid, out_change, cfg_ready and cfg_busy are all 0.
- Settle filter, every cycle in any state:
  - If in != in_q: in_q <= in, stab_cnt <= 0, out_valid <= 0.
  - Else if stab_cnt < SETTLE: stab_cnt increments. When it reaches SETTLE: out <= table[in_q] and out_valid <= 1. out_change pulses if the new out differs from the old out.
  - stab_cnt saturates at SETTLE. While saturated, out tracks table[in_q].
- State machine: RUN, LOAD.
  - RUN -> LOAD on cfg_start; bit_cnt <= 0.
  - In LOAD, each accepted bit shifts into the shadow table MSB-first: the first bit is row 2^N_IN-1 and the last bit is row 0. bit_cnt increments per accepted bit.
  - cfg_start while in LOAD restarts the load: bit_cnt <= 0 and all partial bits are discarded. If cfg_start and an accepted bit occur in the same cycle, cfg_start wins and the bit is dropped.
  - LOAD -> RUN on the edge that accepts bit 2^N_IN. On that same edge, the active table <= the completed shadow, stab_cnt <= 0 and out_valid <= 0. out holds its value, then re-evaluates after SETTLE cycles.
- The active table never changes mid-load; evaluation in LOAD uses the old table.
- If an input change and a table commit happen on the same edge, both take effect: in_q updates and stab_cnt resets to 0 once.
- bit_cnt width: clog2(2^N_IN + 1) bits. stab_cnt width: 8 bits.

## Timing
- Edge E captures a new input vector (in_q updates). out and out_valid update at edge E+SETTLE, provided in stays constant through that edge. out_change is high for the cycle after E+SETTLE only.
- A glitch shorter than SETTLE+1 cycles never reaches out. out_valid is low from edge E until the input settles again.
- Table load takes exactly 2^N_IN accepted bits. Gaps in cfg_valid are allowed and have no timeout.
- cfg_ready and cfg_busy rise one edge after cfg_start and fall on the commit edge.
- Reset asserted mid-load aborts the load: the shadow table is lost and the active table returns to INIT.

## Test plan
- N_IN=3, INIT=8'h90, SETTLE=4. Release reset with in=3'b000:
  - Expect out=0, out_valid=1 four edges after release, and no out_change.
  - Drive in=3'b100: out=1 and out_valid=1 at capture+4, with a single out_change pulse.
- Glitch rejection, same setup, in=3'b100 settled:
  - Drive 3'b000 for 2 cycles, then back to 3'b100.
  - out stays 1 with no out_change. out_valid is low for 2+4 cycles, then high.
- Reprogram with in=3'b000 held:
  - cfg_start, then bits 0,0,0,0,1,0,0,1 (table 8'h09) with random cfg_valid gaps.
  - out stays 0 through the load. At commit, out_valid drops; 4 edges later out=1, with an out_change pulse.
- Restart and collision:
  - Send 5 bits, pulse cfg_start, then send 8 bits of 8'hFF, with one cfg_start coinciding with a valid bit.
  - Only the final 8 bits are committed. Every row then reads 1.
- Reset mid-load: assert rst_n low after 3 bits.
  - All outputs are 0 during reset and cfg_busy=0.
  - After release, the table equals INIT=8'h90 (verify rows 4 and 7 give 1 and the others give 0).
- Parameter sweep, N_IN=4, INIT=16'hA5C3, SETTLE=1:
  - Exhaustively step all 16 rows, holding each for 3 cycles.
  - out equals INIT[row] at capture+1, and out_change pulses exactly on value changes.
